// File: rtl/branch_defines.sv
// Branch unit FSM state encoding.
// No logic; types only.
// No flow control; types only.
package branch_defines;
    typedef enum logic [1:0] {
        BR_IDLE     = 2'd0,
        BR_EVAL     = 2'd1,
        BR_REDIRECT = 2'd2
    } br_state_t;
endpackage

// File: rtl/com_defines.sv
// Comparator opcode encodings shared by decode and the branch unit.
// No logic; constants only.
// No flow control; constants only.
package com_defines;
    localparam int COM_OP_END = 2;

    localparam logic [COM_OP_END:0] COM_OP_EQ  = 3'd0;
    localparam logic [COM_OP_END:0] COM_OP_NE  = 3'd1;
    localparam logic [COM_OP_END:0] COM_OP_LT  = 3'd2;
    localparam logic [COM_OP_END:0] COM_OP_GE  = 3'd3;
    localparam logic [COM_OP_END:0] COM_OP_LTU = 3'd4;
    localparam logic [COM_OP_END:0] COM_OP_GEU = 3'd5;
    localparam logic [COM_OP_END:0] COM_OP_ONE = 3'd6;
endpackage

// File: rtl/reg_defines.sv
// Register-file width definitions shared across the core.
// No logic; constants only.
// No flow control; constants only.
package reg_defines;
    localparam int REG_W_END = 31;
endpackage

// File: rtl/com.sv
// Branch condition comparator: signed/unsigned compares plus constant-true for jumps.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module com
    import com_defines::*;
    import reg_defines::*;
(
    input  logic [COM_OP_END:0] op,
    input  logic [REG_W_END:0]  lhs,
    input  logic [REG_W_END:0]  rhs,
    output logic                result
);

    // Evaluate the condition; unrecognised opcodes resolve as not taken.
    always_comb begin
        result = 1'b0;
        case (op)
            COM_OP_EQ:  result = (lhs == rhs);
            COM_OP_NE:  result = (lhs != rhs);
            COM_OP_LT:  result = ($signed(lhs) <  $signed(rhs));
            COM_OP_GE:  result = ($signed(lhs) >= $signed(rhs));
            COM_OP_LTU: result = (lhs <  rhs);
            COM_OP_GEU: result = (lhs >= rhs);
            COM_OP_ONE: result = 1'b1;
            default:    result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution between decode and fetch; one request in flight. Optional stats: BRANCH_STATS_EN.
// Latency: accept N -> not-taken/misaligned done at N+1; redirect valid from N+2 until fetch accepts.
// Backpressure: req_ready only in IDLE without flush; redirect held stable until redir_ready.
module branch_unit
    import com_defines::*;
    import reg_defines::*;
    import branch_defines::*;
#(
    parameter int RESET_PC_ALIGN = 2
`ifdef BRANCH_STATS_EN
    ,
    parameter int STAT_W         = 32
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [COM_OP_END:0] req_op,
    input  logic [REG_W_END:0]  req_lhs,
    input  logic [REG_W_END:0]  req_rhs,
    input  logic [REG_W_END:0]  req_base,
    input  logic [REG_W_END:0]  req_offset,
    input  logic                req_is_jalr,
    output logic                redir_valid,
    input  logic                redir_ready,
    output logic [REG_W_END:0]  redir_pc,
    output logic                done,
    output logic                done_taken,
    output logic                misalign
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_branches,
    output logic [STAT_W-1:0]   stat_taken,
    output logic [STAT_W-1:0]   stat_misalign
`endif
);

    br_state_t             state_q;
    br_state_t             state_d;
    logic [COM_OP_END:0]   op_q;
    logic [REG_W_END:0]    lhs_q;
    logic [REG_W_END:0]    rhs_q;
    logic [REG_W_END:0]    target_q;
    logic [REG_W_END:0]    target_d;
    logic                  taken;
    logic                  target_misaligned;
    logic                  accept;

    com u_com (
        .op     (op_q),
        .lhs    (lhs_q),
        .rhs    (rhs_q),
        .result (taken)
    );

    assign target_misaligned = (target_q[RESET_PC_ALIGN-1:0] != '0);
    assign redir_pc          = target_q;

    // Target adder: wraps modulo 2^REG_W; JALR drops bit 0 before the alignment check.
    always_comb begin
        target_d = req_base + req_offset;
        if (req_is_jalr) begin
            target_d[0] = 1'b0;
        end
    end

    // FSM next state and outputs; flush/reset squash every output for the cycle.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        redir_valid = 1'b0;
        done        = 1'b0;
        done_taken  = 1'b0;
        misalign    = 1'b0;
        accept      = 1'b0;
        case (state_q)
            BR_IDLE: begin
                req_ready = ~flush & ~reset;
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = BR_EVAL;
                end
            end
            BR_EVAL: begin
                if (!taken) begin
                    done    = 1'b1;
                    state_d = BR_IDLE;
                end else if (target_misaligned) begin
                    misalign   = 1'b1;
                    done       = 1'b1;
                    done_taken = 1'b1;
                    state_d    = BR_IDLE;
                end else begin
                    state_d = BR_REDIRECT;
                end
            end
            BR_REDIRECT: begin
                redir_valid = 1'b1;
                if (redir_ready) begin
                    done       = 1'b1;
                    done_taken = 1'b1;
                    state_d    = BR_IDLE;
                end
            end
            default: state_d = BR_IDLE;
        endcase
        if (flush || reset) begin
            redir_valid = 1'b0;
            done        = 1'b0;
            done_taken  = 1'b0;
            misalign    = 1'b0;
            state_d     = BR_IDLE;
        end
    end

    // State register and operand latches captured on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BR_IDLE;
            op_q     <= '0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= req_op;
                lhs_q    <= req_lhs;
                rhs_q    <= req_rhs;
                target_q <= target_d;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating retirement statistics; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches <= '0;
            stat_taken    <= '0;
            stat_misalign <= '0;
        end else begin
            if (done && stat_branches != '1) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if (done && done_taken && stat_taken != '1) begin
                stat_taken <= stat_taken + 1'b1;
            end
            if (misalign && stat_misalign != '1) begin
                stat_misalign <= stat_misalign + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants.
module tb_branch_unit;
    import com_defines::*;
    import reg_defines::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic                req_valid;
    logic                req_ready;
    logic [COM_OP_END:0] req_op;
    logic [REG_W_END:0]  req_lhs;
    logic [REG_W_END:0]  req_rhs;
    logic [REG_W_END:0]  req_base;
    logic [REG_W_END:0]  req_offset;
    logic                req_is_jalr;
    logic                redir_valid;
    logic                redir_ready;
    logic [REG_W_END:0]  redir_pc;
    logic                done;
    logic                done_taken;
    logic                misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0]         stat_branches;
    logic [31:0]         stat_taken;
    logic [31:0]         stat_misalign;
`endif

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_tk = 0;
    int exp_mis = 0;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_lhs     (req_lhs),
        .req_rhs     (req_rhs),
        .req_base    (req_base),
        .req_offset  (req_offset),
        .req_is_jalr (req_is_jalr),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .done        (done),
        .done_taken  (done_taken),
        .misalign    (misalign)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken),
        .stat_misalign (stat_misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Presents one request for a cycle, then returns at the sample point of the following cycle (N+1).
    task automatic send(input logic [COM_OP_END:0] op, input logic [31:0] lhs, input logic [31:0] rhs,
                        input logic [31:0] base, input logic [31:0] off, input logic jalr);
        next_cycle();
        req_valid   = 1'b1;
        req_op      = op;
        req_lhs     = lhs;
        req_rhs     = rhs;
        req_base    = base;
        req_offset  = off;
        req_is_jalr = jalr;
        #1;
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_op      = '0;
        req_lhs     = '0;
        req_rhs     = '0;
        req_base    = '0;
        req_offset  = '0;
        req_is_jalr = 1'b0;
        redir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_req_ready",   {31'b0, req_ready},   32'd1);
        check("rst_redir_valid", {31'b0, redir_valid}, 32'd0);
        check("rst_done",        {31'b0, done},        32'd0);
        check("rst_done_taken",  {31'b0, done_taken},  32'd0);
        check("rst_misalign",    {31'b0, misalign},    32'd0);
        check("rst_redir_pc",    redir_pc,             32'd0);

        // BEQ taken; fetch stalls for three redirect cycles, accepts on the fourth.
        send(COM_OP_EQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        check("beq_n1_done",      {31'b0, done},        32'd0);
        check("beq_n1_req_ready", {31'b0, req_ready},   32'd0);
        check("beq_n1_redir",     {31'b0, redir_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check("beq_stall_valid", {31'b0, redir_valid}, 32'd1);
            check("beq_stall_pc",    redir_pc,             32'h120);
            check("beq_stall_ready", {31'b0, req_ready},   32'd0);
            check("beq_stall_done",  {31'b0, done},        32'd0);
        end
        next_cycle();
        redir_ready = 1'b1;
        #1;
        check("beq_hs_done",  {31'b0, done},        32'd1);
        check("beq_hs_taken", {31'b0, done_taken},  32'd1);
        check("beq_hs_valid", {31'b0, redir_valid}, 32'd1);
        exp_br++; exp_tk++;
        next_cycle();
        redir_ready = 1'b0;
        #1;
        check("beq_after_ready", {31'b0, req_ready},   32'd1);
        check("beq_after_valid", {31'b0, redir_valid}, 32'd0);
        check("beq_after_done",  {31'b0, done},        32'd0);

        // BLT signed -1 < 1: taken; fetch ready before valid so handshake lands at N+2.
        redir_ready = 1'b1;
        send(COM_OP_LT, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h4, 1'b0);
        check("blt_n1_done", {31'b0, done}, 32'd0);
        next_cycle();
        #1;
        check("blt_n2_valid", {31'b0, redir_valid}, 32'd1);
        check("blt_n2_pc",    redir_pc,             32'h1004);
        check("blt_n2_done",  {31'b0, done},        32'd1);
        check("blt_n2_taken", {31'b0, done_taken},  32'd1);
        exp_br++; exp_tk++;
        next_cycle();
        redir_ready = 1'b0;

        // BLTU same operands: not taken, retires at N+1.
        send(COM_OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h4, 1'b0);
        check("bltu_done",      {31'b0, done},       32'd1);
        check("bltu_taken",     {31'b0, done_taken}, 32'd0);
        check("bltu_misalign",  {31'b0, misalign},   32'd0);
        check("bltu_b2b_ready", {31'b0, req_ready},  32'd0);
        exp_br++;
        next_cycle();
        #1;
        check("bltu_idle_ready", {31'b0, req_ready},   32'd1);
        check("bltu_idle_valid", {31'b0, redir_valid}, 32'd0);

        // JALR to 0x203: bit 0 cleared gives 0x202, still misaligned for 4-byte fetch.
        send(COM_OP_ONE, 32'd0, 32'd0, 32'h203, 32'h0, 1'b1);
        check("jalr_misalign", {31'b0, misalign},    32'd1);
        check("jalr_done",     {31'b0, done},        32'd1);
        check("jalr_taken",    {31'b0, done_taken},  32'd1);
        check("jalr_valid",    {31'b0, redir_valid}, 32'd0);
        check("jalr_target",   redir_pc,             32'h202);
        exp_br++; exp_tk++; exp_mis++;
        next_cycle();
        #1;
        check("jalr_next_valid",    {31'b0, redir_valid}, 32'd0);
        check("jalr_next_misalign", {31'b0, misalign},    32'd0);
        check("jalr_next_ready",    {31'b0, req_ready},   32'd1);

        // Target wraps past 2^32.
        redir_ready = 1'b1;
        send(COM_OP_EQ, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 1'b0);
        next_cycle();
        #1;
        check("wrap_pc",   redir_pc,             32'h10);
        check("wrap_done", {31'b0, done},        32'd1);
        exp_br++; exp_tk++;
        next_cycle();
        redir_ready = 1'b0;

        // Unknown opcode resolves as not taken.
        send(3'd7, 32'd1, 32'd1, 32'h40, 32'h0, 1'b0);
        check("unk_done",  {31'b0, done},       32'd1);
        check("unk_taken", {31'b0, done_taken}, 32'd0);
        exp_br++;
        next_cycle();

        // Flush while redirecting drops the redirect without retiring.
        send(COM_OP_NE, 32'd1, 32'd2, 32'h400, 32'h8, 1'b0);
        next_cycle();
        #1;
        check("fl_pre_valid", {31'b0, redir_valid}, 32'd1);
        check("fl_pre_pc",    redir_pc,             32'h408);
        flush = 1'b1;
        #1;
        check("fl_now_valid", {31'b0, redir_valid}, 32'd0);
        check("fl_now_done",  {31'b0, done},        32'd0);
        next_cycle();
        flush = 1'b0;
        #1;
        check("fl_next_valid", {31'b0, redir_valid}, 32'd0);
        check("fl_next_done",  {31'b0, done},        32'd0);
        check("fl_next_ready", {31'b0, req_ready},   32'd1);

        // Flush beats a same-cycle request in IDLE.
        next_cycle();
        req_valid = 1'b1;
        req_op    = COM_OP_EQ;
        flush     = 1'b1;
        #1;
        check("flpri_ready", {31'b0, req_ready}, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        check("flpri_done",  {31'b0, done},      32'd0);
        check("flpri_ready2", {31'b0, req_ready}, 32'd1);

`ifdef BRANCH_STATS_EN
        check("stat_branches_pre", stat_branches, exp_br);
        check("stat_taken_pre",    stat_taken,    exp_tk);
        check("stat_misalign_pre", stat_misalign, exp_mis);
`endif

        // Reset during EVAL: nothing retires, redirect state cleared.
        send(COM_OP_EQ, 32'd3, 32'd3, 32'h800, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_eval_done", {31'b0, done}, 32'd0);
        next_cycle();
        reset = 1'b0;
        exp_br = 0; exp_tk = 0; exp_mis = 0;
        #1;
        check("rst_eval_ready", {31'b0, req_ready},   32'd1);
        check("rst_eval_valid", {31'b0, redir_valid}, 32'd0);
        check("rst_eval_pc",    redir_pc,             32'd0);
        check("rst_eval_done2", {31'b0, done},        32'd0);

        // Post-reset traffic for the statistics counters.
        send(COM_OP_GEU, 32'd1, 32'd2, 32'h0, 32'h0, 1'b0);
        check("post_bgeu_done", {31'b0, done}, 32'd1);
        exp_br++;
        send(COM_OP_ONE, 32'd0, 32'd0, 32'h10, 32'h2, 1'b0);
        check("post_jal_mis", {31'b0, misalign}, 32'd1);
        exp_br++; exp_tk++; exp_mis++;
        next_cycle();
        #1;
`ifdef BRANCH_STATS_EN
        check("stat_branches", stat_branches, exp_br);
        check("stat_taken",    stat_taken,    exp_tk);
        check("stat_misalign", stat_misalign, exp_mis);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
